// File: rtl/tile_sprite_addr_gen.sv
// Tile/sprite ROM address generator: raster-tracking tile counters, grid region
// flag and an animation-frame sequencer feeding the sprite block ROM.
module tile_sprite_addr_gen #(
   parameter int TILE_W     = 30,
   parameter int TILE_H     = 30,
   parameter int X0         = 49,
   parameter int Y0         = 191,
   parameter int COLS       = 19,
   parameter int ROWS       = 9,
   parameter int NUM_FRAMES = 4,
   parameter int FRAME_DIV  = 8,
   parameter int ADDR_W     = 12,
   parameter int COL_W      = 5,
   parameter int ROW_W      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pix_en,
   input  logic [9:0]                    h_cnt,
   input  logic [9:0]                    v_cnt,
   input  logic                          frame_tick,
   input  logic                          anim_en,
   output logic [ADDR_W-1:0]             pixel_addr,
   output logic [COL_W-1:0]              tile_col,
   output logic [ROW_W-1:0]              tile_row,
   output logic                          in_region,
   output logic [$clog2(NUM_FRAMES)-1:0] anim_frame
);

   localparam int TX_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int TY_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int AF_W  = $clog2(NUM_FRAMES);
   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [9:0]       H_LO     = 10'(X0);
   localparam logic [9:0]       H_HI     = 10'(X0 + COLS * TILE_W);
   localparam logic [9:0]       V_LO     = 10'(Y0);
   localparam logic [9:0]       V_HI     = 10'(Y0 + ROWS * TILE_H);
   localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(TILE_W - 1);
   localparam logic [TY_W-1:0]  TY_LAST  = TY_W'(TILE_H - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [AF_W-1:0]  AF_LAST  = AF_W'(NUM_FRAMES - 1);

   typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} sync_e;

   sync_e             state_q, state_d;
   logic [TX_W-1:0]   tx_q, tx_d;
   logic [TY_W-1:0]   ty_q, ty_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [AF_W-1:0]   anim_q, anim_d;
   logic [ADDR_W-1:0] addr_d;
   logic              line_start, h_in, v_in, region_d;

   assign line_start = pix_en && (h_cnt == 10'd0);
   assign h_in       = (h_cnt >= H_LO) && (h_cnt < H_HI);
   assign v_in       = (v_cnt >= V_LO) && (v_cnt < V_HI);

   // Sync FSM: nothing is trusted until the first grid line of a frame is seen.
   always_comb begin
      state_d = state_q;
      case (state_q)
         UNSYNC:  if (line_start && (v_cnt == V_LO)) state_d = SYNC;
         SYNC:    state_d = SYNC;
         default: state_d = UNSYNC;
      endcase
   end

   always_comb begin
      ty_d  = ty_q;
      row_d = row_q;
      if (line_start) begin
         if (v_cnt == V_LO) begin
            ty_d  = '0;
            row_d = '0;
         end else if ((v_cnt > V_LO) && (v_cnt < V_HI)) begin
            if (ty_q == TY_LAST) begin
               ty_d  = '0;
               row_d = row_q + ROW_W'(1);
            end else begin
               ty_d  = ty_q + TY_W'(1);
            end
         end
      end
   end

   always_comb begin
      tx_d  = tx_q;
      col_d = col_q;
      if (pix_en) begin
         if (h_cnt == H_LO) begin
            tx_d  = '0;
            col_d = '0;
         end else if ((h_cnt > H_LO) && (h_cnt < H_HI)) begin
            if (tx_q == TX_LAST) begin
               tx_d  = '0;
               col_d = col_q + COL_W'(1);
            end else begin
               tx_d  = tx_q + TX_W'(1);
            end
         end
      end
   end

   // Address uses the frame register as it stood before any coincident tick.
   always_comb begin
      region_d = (state_d == SYNC) && h_in && v_in;
      addr_d   = ADDR_W'(anim_q) * ADDR_W'(TILE_W * TILE_H)
               + ADDR_W'(ty_d) * ADDR_W'(TILE_W)
               + ADDR_W'(tx_d);
   end

   always_comb begin
      div_d  = div_q;
      anim_d = anim_q;
      if (frame_tick && anim_en) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            anim_d = (anim_q == AF_LAST) ? '0 : anim_q + AF_W'(1);
         end else begin
            div_d  = div_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= UNSYNC;
         tx_q       <= '0;
         ty_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         div_q      <= '0;
         anim_q     <= '0;
         pixel_addr <= '0;
         tile_col   <= '0;
         tile_row   <= '0;
         in_region  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         col_q   <= col_d;
         row_q   <= row_d;
         div_q   <= div_d;
         anim_q  <= anim_d;
         if (pix_en) begin
            in_region  <= region_d;
            pixel_addr <= region_d ? addr_d : '0;
            tile_col   <= region_d ? col_d : '0;
            tile_row   <= region_d ? row_d : '0;
         end
      end
   end

   assign anim_frame = anim_q;

endmodule

// File: tb/tb_tile_sprite_addr_gen.sv
// Bench for tile_sprite_addr_gen: raster sweeps with random gaps and frame ticks,
// checked every clock against an arithmetic reference of the tile grid.
module tb_tile_sprite_addr_gen;

   localparam int TILE_W     = 30;
   localparam int TILE_H     = 30;
   localparam int X0         = 49;
   localparam int Y0         = 191;
   localparam int COLS       = 19;
   localparam int ROWS       = 9;
   localparam int NUM_FRAMES = 4;
   localparam int FRAME_DIV  = 8;
   localparam int H_END      = X0 + COLS * TILE_W;
   localparam int V_END      = Y0 + ROWS * TILE_H;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_en = 1'b0;
   logic [9:0]  h_cnt = '0;
   logic [9:0]  v_cnt = '0;
   logic        frame_tick = 1'b0;
   logic        anim_en = 1'b0;
   logic [11:0] pixel_addr;
   logic [4:0]  tile_col;
   logic [3:0]  tile_row;
   logic        in_region;
   logic [1:0]  anim_frame;

   tile_sprite_addr_gen dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .frame_tick(frame_tick), .anim_en(anim_en), .pixel_addr(pixel_addr),
      .tile_col(tile_col), .tile_row(tile_row), .in_region(in_region),
      .anim_frame(anim_frame)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state
   bit m_sync = 0;
   int m_div = 0, m_frame = 0;
   int m_addr = 0, m_col = 0, m_row = 0;
   bit m_inr = 0;

   int spot_mode = 0;
   bit coinc = 0;
   int rand_line = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d t=%0t)", tag, obs, exp, h_cnt, v_cnt, $time);
      end
   endtask

   task automatic model_step(input bit pe, input int h, input int v, input bit ft, input bit ae, input bit r);
      bit inr;
      if (r) begin
         m_sync = 0; m_div = 0; m_frame = 0;
         m_addr = 0; m_col = 0; m_row = 0; m_inr = 0;
      end else begin
         if (pe) begin
            if (h == 0 && v == Y0) m_sync = 1;
            inr = m_sync && h >= X0 && h < H_END && v >= Y0 && v < V_END;
            m_inr = inr;
            if (inr) begin
               m_col  = (h - X0) / TILE_W;
               m_row  = (v - Y0) / TILE_H;
               m_addr = m_frame * TILE_W * TILE_H + ((v - Y0) % TILE_H) * TILE_W + (h - X0) % TILE_W;
            end else begin
               m_col = 0; m_row = 0; m_addr = 0;
            end
         end
         if (ft && ae) begin
            m_div++;
            if (m_div == FRAME_DIV) begin
               m_div = 0;
               m_frame = (m_frame + 1) % NUM_FRAMES;
            end
         end
      end
   endtask

   task automatic tick(input bit pe, input int h, input int v, input bit ft, input bit r);
      pix_en = pe; h_cnt = 10'(h); v_cnt = 10'(v); frame_tick = ft; rst = r;
      @(posedge clk);
      model_step(pe, h, v, ft, anim_en, r);
      #1;
      chk("in_region",  32'(in_region),  32'(m_inr));
      chk("pixel_addr", 32'(pixel_addr), 32'(m_addr));
      chk("tile_col",   32'(tile_col),   32'(m_col));
      chk("tile_row",   32'(tile_row),   32'(m_row));
      chk("anim_frame", 32'(anim_frame), 32'(m_frame));
   endtask

   function automatic bit rnd_ft(input bit rnd);
      return rnd && ($urandom_range(0, 63) == 0);
   endfunction

   task automatic gap(input int n, input bit rnd);
      for (int i = 0; i < n; i++)
         tick(0, $urandom_range(0, 799), $urandom_range(0, 524), rnd_ft(rnd), 0);
   endtask

   function automatic bit is_sweep(input int v);
      return v == 191 || v == 200 || v == 221 || v == 300 || v == 400 ||
             v == 460 || v == 461 || v == rand_line;
   endfunction

   task automatic spot(input int h, input int v);
      if (spot_mode == 1) begin
         if (h == 49 && v == 191)  begin chk("spot_origin_addr", 32'(pixel_addr), 0); chk("spot_origin_in", 32'(in_region), 1); end
         if (h == 108 && v == 221) begin chk("spot_108_221_addr", 32'(pixel_addr), 29);
                                         chk("spot_108_221_col", 32'(tile_col), 1);
                                         chk("spot_108_221_row", 32'(tile_row), 1); end
         if (h == 48 && v == 200)  chk("spot_left_edge", 32'(in_region), 0);
         if (h == 619 && v == 200) chk("spot_right_edge", 32'(in_region), 0);
         if (h == 100 && v == 461) chk("spot_bottom_edge", 32'(in_region), 0);
         if (h == 618 && v == 460) begin chk("spot_last_addr", 32'(pixel_addr), 899);
                                         chk("spot_last_col", 32'(tile_col), 18);
                                         chk("spot_last_row", 32'(tile_row), 8); end
      end else if (spot_mode == 2) begin
         if (h == 49 && v == 191) chk("spot_frame1_addr", 32'(pixel_addr), 900);
      end
   endtask

   task automatic run_frame(input int rst_line, input bit rnd);
      rand_line = rnd ? int'($urandom_range(Y0, V_END - 1)) : -1;
      for (int v = 0; v < 525; v++) begin
         if (rnd && (v % 32 == 0)) anim_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) gap($urandom_range(1, 3), rnd);
         if (v == rst_line) tick(1, 0, v, 1, 1);
         else               tick(1, 0, v, rnd_ft(rnd), 0);
         if (is_sweep(v)) begin
            for (int h = X0 - 2; h <= H_END + 1; h++) begin
               if ($urandom_range(0, 15) == 0) gap($urandom_range(1, 3), rnd);
               if (v == 221 && h == 150) gap(3, rnd);
               tick(1, h, v, rnd_ft(rnd) || (coinc && v == 221 && h == 200), 0);
               spot(h, v);
            end
         end
      end
      tick(0, 0, 0, 1, 0);
   endtask

   initial begin
      tick(0, 0, 0, 0, 1);
      tick(1, 49, 191, 1, 1);
      chk("reset_addr", 32'(pixel_addr), 0);
      chk("reset_in", 32'(in_region), 0);
      chk("reset_frame", 32'(anim_frame), 0);

      spot_mode = 1;
      run_frame(-1, 0);
      chk("frozen_frame", 32'(anim_frame), 0);

      anim_en = 1;
      for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0);
      chk("anim_after_8", 32'(anim_frame), 1);

      spot_mode = 2; coinc = 1;
      run_frame(-1, 0);
      spot_mode = 0; coinc = 0;

      for (int i = 0; i < 22; i++) tick(0, 0, 0, 1, 0);
      chk("anim_wrap_32", 32'(anim_frame), 0);

      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
      anim_en = 0;
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);
      chk("anim_freeze", 32'(anim_frame), 0);
      anim_en = 1;
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);
      chk("anim_div_kept", 32'(anim_frame), 1);

      run_frame(300, 1);
      run_frame(-1, 1);
      run_frame(-1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
